// File: rtl/bcd_fnd_scan.sv
// rtl/bcd_fnd_scan.sv - 4-digit multiplexed 7-segment scan driver with frame latch
//
// Purpose:
//   Time-multiplexes four BCD digits onto a common-segment FND. Each digit slot is
//   SCAN_DIV clocks long. The first clock of each slot is a ghosting guard, with all
//   commons off. A new value is latched only at the ONE->THO boundary, so one frame
//   never mixes two values. Leading zeros can be blanked.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous reset, active-low
//   tho/hun/ten/one in [3:0] BCD digits (10..15 display as "-")
//   blank_lz     in   1 = blank leading zeros (ones digit never blanked)
//   seg          out  [6:0] segments {g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
//   com          out  [3:0] digit enables, com[3]=tho .. com[0]=one, polarity per COM_ACT_LOW
//   frame_pulse  out  1-cycle pulse after a new value has been latched

module bcd_fnd_scan #(
    parameter int SCAN_DIV    = 50000,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit COM_ACT_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] tho,
    input  logic [3:0] hun,
    input  logic [3:0] ten,
    input  logic [3:0] one,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [3:0] com,
    output logic       frame_pulse
);

    localparam int             CW      = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [6:0]     SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]     COM_OFF = COM_ACT_LOW ? 4'hF : 4'h0;

    // The encoding equals the com bit index of each digit, so the one-hot enable
    // is a plain shift of the state.
    typedef enum logic [1:0] {
        S_ONE = 2'd0,
        S_TEN = 2'd1,
        S_HUN = 2'd2,
        S_THO = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [3:0]     sh_tho_q, sh_hun_q, sh_ten_q, sh_one_q;
    logic [6:0]     seg_q, seg_d;
    logic [3:0]     com_q, com_d;
    logic           fp_q, fp_d;
    logic           guard_q;

    logic           tick;
    logic           frame_start;
    logic [3:0]     digit;
    logic           blank;
    logic [6:0]     pat;
    logic [3:0]     onehot;

    assign tick        = (cnt_q == CNT_MAX);
    assign frame_start = tick && (state_q == S_ONE);

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h40;
        endcase
        return p;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_ONE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: advance one digit per prescaler tick
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                S_THO:   state_d = S_HUN;
                S_HUN:   state_d = S_TEN;
                S_TEN:   state_d = S_ONE;
                default: state_d = S_THO;
            endcase
        end
    end

    // Output logic. The pattern is built for the digit being entered (state_d).
    // The thousands digit comes straight from the inputs, because the shadow is
    // being loaded on the same edge.
    always_comb begin
        digit = sh_one_q;
        blank = 1'b0;
        case (state_d)
            S_THO: begin
                digit = tho;
                blank = (tho == 4'd0);
            end
            S_HUN: begin
                digit = sh_hun_q;
                blank = (sh_tho_q == 4'd0) && (sh_hun_q == 4'd0);
            end
            S_TEN: begin
                digit = sh_ten_q;
                blank = (sh_tho_q == 4'd0) && (sh_hun_q == 4'd0) && (sh_ten_q == 4'd0);
            end
            default: begin
                digit = sh_one_q;
                blank = 1'b0;
            end
        endcase

        pat    = (blank_lz && blank) ? 7'h00 : bcd_to_seg(digit);
        onehot = 4'(4'b0001 << state_q);

        seg_d = seg_q;
        com_d = com_q;
        if (tick) begin
            seg_d = SEG_ACT_LOW ? ~pat : pat;
            com_d = COM_OFF;
        end else if (guard_q) begin
            com_d = COM_ACT_LOW ? ~onehot : onehot;
        end
        fp_d = frame_start;
    end

    // Prescaler, frame shadow and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            sh_tho_q <= 4'd0;
            sh_hun_q <= 4'd0;
            sh_ten_q <= 4'd0;
            sh_one_q <= 4'd0;
            seg_q    <= SEG_OFF;
            com_q    <= COM_OFF;
            fp_q     <= 1'b0;
            guard_q  <= 1'b0;
        end else begin
            cnt_q   <= tick ? '0 : cnt_q + CW'(1);
            seg_q   <= seg_d;
            com_q   <= com_d;
            fp_q    <= fp_d;
            guard_q <= tick;
            if (frame_start) begin
                sh_tho_q <= tho;
                sh_hun_q <= hun;
                sh_ten_q <= ten;
                sh_one_q <= one;
            end
        end
    end

    assign seg         = seg_q;
    assign com         = com_q;
    assign frame_pulse = fp_q;

endmodule

// File: tb/tb_bcd_fnd_scan.sv
// tb/tb_bcd_fnd_scan.sv - scoreboard bench for bcd_fnd_scan (SCAN_DIV=4, active-low)

module tb_bcd_fnd_scan;

    localparam int SCAN_DIV = 4;
    localparam int FRAME    = 4 * SCAN_DIV;

    typedef struct packed {
        logic [3:0] com;
        logic [6:0] seg;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] tho, hun, ten, one;
    logic       blank_lz;
    logic [6:0] seg;
    logic [3:0] com;
    logic       frame_pulse;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    bcd_fnd_scan #(
        .SCAN_DIV    (SCAN_DIV),
        .SEG_ACT_LOW (1'b1),
        .COM_ACT_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tho         (tho),
        .hun         (hun),
        .ten         (ten),
        .one         (one),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .com         (com),
        .frame_pulse (frame_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_pat(input logic [3:0] d);
        logic [6:0] t [0:9];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return (d > 4'd9) ? 7'h40 : t[d];
    endfunction

    // Drive a new value and queue the four slots the next frame must show.
    task automatic load(input logic [3:0] t, input logic [3:0] h, input logic [3:0] te,
                        input logic [3:0] o, input logic blz);
        exp_t e;
        tho = t; hun = h; ten = te; one = o; blank_lz = blz;
        e.com = 4'h7; e.seg = (blz && t == 0) ? 7'h7F : ~ref_pat(t);
        sb.push_back(e);
        e.com = 4'hB; e.seg = (blz && t == 0 && h == 0) ? 7'h7F : ~ref_pat(h);
        sb.push_back(e);
        e.com = 4'hD; e.seg = (blz && t == 0 && h == 0 && te == 0) ? 7'h7F : ~ref_pat(te);
        sb.push_back(e);
        e.com = 4'hE; e.seg = ~ref_pat(o);
        sb.push_back(e);
    endtask

    task automatic wait_fp();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_pulse && n < 4 * FRAME);
        if (!frame_pulse) check("frame_pulse_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: each slot popped at the first cycle com leaves the all-off state
    logic [3:0] prev_com;
    exp_t       cur;
    logic       cur_valid, first_slot, fp_armed, per_valid;
    int         run, f_run, per;

    always @(negedge clk) begin
        if (!rst) begin
            prev_com = 4'hF; cur_valid = 1'b0; first_slot = 1'b1; fp_armed = 1'b0;
            per_valid = 1'b0; run = 0; f_run = 0; per = 0;
        end else begin
            if (com != 4'hF) begin
                if (prev_com == 4'hF) begin
                    if (!first_slot) check("guard_len", f_run, 1);
                    first_slot = 1'b0;
                    if (fp_armed) check("frame_first_slot", {28'd0, com}, 32'h7);
                    fp_armed = 1'b0;
                    if (sb.size() == 0) begin
                        check("sb_underflow", 32'd0, 32'd1);
                        cur_valid = 1'b0;
                    end else begin
                        cur = sb.pop_front();
                        cur_valid = 1'b1;
                    end
                    run = 0;
                end
                run++;
                f_run = 0;
                if (cur_valid) begin
                    check("slot_com", {28'd0, com}, {28'd0, cur.com});
                    check("slot_seg", {25'd0, seg}, {25'd0, cur.seg});
                end
            end else begin
                if (prev_com != 4'hF) check("slot_len", run, SCAN_DIV - 1);
                f_run++;
            end
            per++;
            if (frame_pulse) begin
                if (per_valid) check("frame_period", per, FRAME);
                per = 0;
                per_valid = 1'b1;
                fp_armed = 1'b1;
            end
            prev_com = com;
        end
    end

    initial begin
        rst = 1'b0;
        load(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_com", {28'd0, com}, 32'hF);
        check("rst_fp", {31'd0, frame_pulse}, 32'd0);

        // First frame: three counting cycles, then the tick cycle, all with com off
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("first_com_off", {28'd0, com}, 32'hF);
            check("first_fp", {31'd0, frame_pulse}, (i == 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("first_com_tho", {28'd0, com}, 32'h7);
        repeat (12) @(negedge clk);

        load(4'd0, 4'd0, 4'd0, 4'd7, 1'b1);
        wait_fp(); repeat (13) @(negedge clk);
        load(4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        wait_fp(); repeat (13) @(negedge clk);
        load(4'd0, 4'd5, 4'd0, 4'd3, 1'b1);
        wait_fp(); repeat (13) @(negedge clk);
        load(4'hA, 4'd0, 4'd1, 4'd2, 1'b1);
        wait_fp(); repeat (13) @(negedge clk);
        load(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        wait_fp();
        // Change the value mid-frame, during the TEN slot
        repeat (9) @(negedge clk);
        load(4'd9, 4'd9, 4'd9, 4'd9, 1'b0);
        wait_fp();

        // Asynchronous reset in the HUN slot blanks without a clock edge
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_seg", {25'd0, seg}, 32'h7F);
        check("mid_rst_com", {28'd0, com}, 32'hF);
        check("mid_rst_fp", {31'd0, frame_pulse}, 32'd0);
        sb.delete();
        load(4'd5, 4'd6, 4'd7, 4'd8, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_fp();
        repeat (14) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
